int8_mac_sequencer: RTL and testbench

Initiator for the pipelined INT8 MAC's input stream. It reads one activation vector and N weight rows from single-port synchronous memories and issues them as a back-to-back En/clear/last beat stream with the quantization parameters. It then collects the N requantized INT8 results from the MAC's Q3 output and writes them into a result memory. It sits between the layer controller (start/done) and one MAC instance.

---
 rtl/int8_mac_pkg.sv | 18 +
 rtl/int8_mac_result_collector.sv | 60 ++++++
 rtl/int8_mac_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_int8_mac_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int8_mac_pkg.sv
// Shared types and default widths for the INT8 MAC input sequencer and its result collector.
package int8_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Beat-to-Q3_valid latency of the downstream MAC.
    localparam int MAC_LATENCY  = 7;

    localparam int DEF_MO_WIDTH = 32;
    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_LEN_W    = 10;

endpackage

// File: rtl/int8_mac_result_collector.sv
// Turns MAC Q3 results into result-memory writes at res_base + result count,
// and flags the cycle carrying the final expected result.
module int8_mac_result_collector
    import int8_mac_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_clear,
    input  logic                i_collect,
    input  logic [LEN_W-1:0]    i_n_out,
    input  logic [ADDR_W-1:0]   i_res_base,
    input  logic signed [7:0]   i_q3,
    input  logic                i_q3_valid,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [7:0]          o_data,
    output logic                o_last
);

    logic [LEN_W-1:0] r_cnt;
    logic             r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]       r_data;
    logic             r_last;
    logic             w_accept;
    logic             w_final;

    // Results beyond n_out, or outside an active command, are dropped.
    assign w_accept = i_collect && i_q3_valid && (r_cnt < i_n_out);
    assign w_final  = (r_cnt == i_n_out - LEN_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            r_last  <= w_accept && w_final;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_addr <= i_res_base + ADDR_W'(r_cnt);
                r_data <= i_q3;
            end
        end
    end

    assign o_wr_en = r_wr_en;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/int8_mac_sequencer.sv
// Streams one activation vector against N weight rows into the INT8 MAC as
// back-to-back beats, then collects the N requantized results into memory.
module int8_mac_sequencer
    import int8_mac_pkg::*;
#(
    parameter int MO_WIDTH = DEF_MO_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic [LEN_W-1:0]           k_len,
    input  logic [LEN_W-1:0]           n_out,
    input  logic [ADDR_W-1:0]          act_base,
    input  logic [ADDR_W-1:0]          wgt_base,
    input  logic [ADDR_W-1:0]          res_base,
    input  logic signed [7:0]          cfg_Za,
    input  logic signed [7:0]          cfg_Zw,
    input  logic signed [7:0]          cfg_Zo,
    input  logic signed [MO_WIDTH-1:0] cfg_M0,
    input  logic [5:0]                 cfg_n,
    output logic                       busy,
    output logic                       done,
    output logic                       act_rd_en,
    output logic [ADDR_W-1:0]          act_addr,
    input  logic signed [7:0]          act_data,
    output logic                       wgt_rd_en,
    output logic [ADDR_W-1:0]          wgt_addr,
    input  logic signed [7:0]          wgt_data,
    output logic [LEN_W-1:0]           bias_addr,
    input  logic signed [31:0]         bias_data,
    output logic signed [7:0]          mac_Qa,
    output logic signed [7:0]          mac_Qw,
    output logic signed [7:0]          mac_Za,
    output logic signed [7:0]          mac_Zw,
    output logic signed [7:0]          mac_Zo,
    output logic signed [MO_WIDTH-1:0] mac_M0,
    output logic [5:0]                 mac_n,
    output logic signed [31:0]         mac_bias,
    output logic                       mac_En,
    output logic                       mac_clear,
    output logic                       mac_last,
    input  logic signed [7:0]          mac_Q3,
    input  logic                       mac_Q3_valid,
    output logic                       res_wr_en,
    output logic [ADDR_W-1:0]          res_addr,
    output logic [7:0]                 res_data
);

    state_t r_state;
    state_t w_state_next;

    logic [LEN_W-1:0]           r_k;
    logic [LEN_W-1:0]           r_n;
    logic [ADDR_W-1:0]          r_act_base;
    logic [ADDR_W-1:0]          r_res_base;
    logic signed [7:0]          r_cfg_Za;
    logic signed [7:0]          r_cfg_Zw;
    logic signed [7:0]          r_cfg_Zo;
    logic signed [MO_WIDTH-1:0] r_cfg_M0;
    logic [5:0]                 r_cfg_n;

    logic [LEN_W-1:0]  r_i;
    logic [LEN_W-1:0]  r_j;
    logic [ADDR_W-1:0] r_act_addr;
    logic [ADDR_W-1:0] r_wgt_addr;
    logic              r_rd_en;
    logic              r_beat_en;
    logic              r_beat_clear;
    logic              r_beat_last;
    logic              r_degen_done;

    logic w_accept_start;
    logic w_zero_len;
    logic w_row_last;
    logic w_rd_last;
    logic w_collect;
    logic w_last_wr;

    assign w_accept_start = start && (r_state == IDLE);
    assign w_zero_len     = (k_len == '0) || (n_out == '0);
    assign w_row_last     = (r_i == r_k - LEN_W'(1));
    assign w_rd_last      = w_row_last && (r_j == r_n - LEN_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept_start && !w_zero_len) w_state_next = ISSUE;
            ISSUE:   if (w_rd_last) w_state_next = DRAIN;
            DRAIN:   if (w_last_wr) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A zero-length command never leaves IDLE; its done comes from r_degen_done.
    always_comb begin
        busy      = 1'b0;
        done      = r_degen_done;
        w_collect = 1'b0;
        case (r_state)
            ISSUE: begin
                busy      = 1'b1;
                w_collect = 1'b1;
            end
            DRAIN: begin
                busy      = 1'b1;
                w_collect = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_k          <= '0;
            r_n          <= '0;
            r_act_base   <= '0;
            r_res_base   <= '0;
            r_cfg_Za     <= '0;
            r_cfg_Zw     <= '0;
            r_cfg_Zo     <= '0;
            r_cfg_M0     <= '0;
            r_cfg_n      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_act_addr   <= '0;
            r_wgt_addr   <= '0;
            r_rd_en      <= 1'b0;
            r_beat_en    <= 1'b0;
            r_beat_clear <= 1'b0;
            r_beat_last  <= 1'b0;
            r_degen_done <= 1'b0;
        end else begin
            r_degen_done <= w_accept_start && w_zero_len;
            // Beat stage trails the read stage by the memory read latency.
            r_beat_en    <= r_rd_en;
            r_beat_clear <= r_rd_en && (r_i == '0);
            r_beat_last  <= r_rd_en && w_row_last;
            if (w_accept_start) begin
                r_k        <= k_len;
                r_n        <= n_out;
                r_act_base <= act_base;
                r_res_base <= res_base;
                r_cfg_Za   <= cfg_Za;
                r_cfg_Zw   <= cfg_Zw;
                r_cfg_Zo   <= cfg_Zo;
                r_cfg_M0   <= cfg_M0;
                r_cfg_n    <= cfg_n;
                r_i        <= '0;
                r_j        <= '0;
                r_act_addr <= act_base;
                r_wgt_addr <= wgt_base;
                r_rd_en    <= !w_zero_len;
            end else if (r_state == ISSUE) begin
                // Weight rows are contiguous, so a single running pointer walks them all.
                r_wgt_addr <= r_wgt_addr + ADDR_W'(1);
                if (w_row_last) begin
                    r_i        <= '0;
                    r_act_addr <= r_act_base;
                    if (w_rd_last) begin
                        r_rd_en <= 1'b0;
                    end else begin
                        r_j <= r_j + LEN_W'(1);
                    end
                end else begin
                    r_i        <= r_i + LEN_W'(1);
                    r_act_addr <= r_act_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign act_rd_en = r_rd_en;
    assign wgt_rd_en = r_rd_en;
    assign act_addr  = r_act_addr;
    assign wgt_addr  = r_wgt_addr;
    assign bias_addr = r_j;

    // Read data is passed straight through during beats and zeroed otherwise.
    assign mac_Qa    = r_beat_en ? act_data  : '0;
    assign mac_Qw    = r_beat_en ? wgt_data  : '0;
    assign mac_bias  = r_beat_en ? bias_data : '0;
    assign mac_En    = r_beat_en;
    assign mac_clear = r_beat_clear;
    assign mac_last  = r_beat_last;
    assign mac_Za    = r_cfg_Za;
    assign mac_Zw    = r_cfg_Zw;
    assign mac_Zo    = r_cfg_Zo;
    assign mac_M0    = r_cfg_M0;
    assign mac_n     = r_cfg_n;

    int8_mac_result_collector #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_collector (
        .CLK        (CLK),
        .RST        (RST),
        .i_clear    (w_accept_start),
        .i_collect  (w_collect),
        .i_n_out    (r_n),
        .i_res_base (r_res_base),
        .i_q3       (mac_Q3),
        .i_q3_valid (mac_Q3_valid),
        .o_wr_en    (res_wr_en),
        .o_addr     (res_addr),
        .o_data     (res_data),
        .o_last     (w_last_wr)
    );

endmodule

// File: tb/tb_int8_mac_sequencer.sv
// Bench for int8_mac_sequencer: memory models, a behavioural MAC, and a
// dot-product reference that predicts every read, beat and result write.
module tb_int8_mac_sequencer;
    import int8_mac_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic              start = 1'b0;
    logic [9:0]        k_len = '0, n_out = '0;
    logic [11:0]       act_base = '0, wgt_base = '0, res_base = '0;
    logic signed [7:0] cfg_Za = '0, cfg_Zw = '0, cfg_Zo = '0;
    logic signed [31:0] cfg_M0 = '0;
    logic [5:0]        cfg_n = '0;
    logic              busy, done, act_rd_en, wgt_rd_en;
    logic [11:0]       act_addr, wgt_addr, res_addr;
    logic signed [7:0] act_data = '0, wgt_data = '0;
    logic [9:0]        bias_addr;
    logic signed [31:0] bias_data = '0;
    logic signed [7:0] mac_Qa, mac_Qw, mac_Za, mac_Zw, mac_Zo;
    logic signed [31:0] mac_M0, mac_bias;
    logic [5:0]        mac_n;
    logic              mac_En, mac_clear, mac_last;
    logic signed [7:0] mac_Q3;
    logic              mac_Q3_valid;
    logic              res_wr_en;
    logic [7:0]        res_data;

    int8_mac_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .n_out(n_out),
        .act_base(act_base), .wgt_base(wgt_base), .res_base(res_base),
        .cfg_Za(cfg_Za), .cfg_Zw(cfg_Zw), .cfg_Zo(cfg_Zo), .cfg_M0(cfg_M0), .cfg_n(cfg_n),
        .busy(busy), .done(done),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_addr(bias_addr), .bias_data(bias_data),
        .mac_Qa(mac_Qa), .mac_Qw(mac_Qw), .mac_Za(mac_Za), .mac_Zw(mac_Zw), .mac_Zo(mac_Zo),
        .mac_M0(mac_M0), .mac_n(mac_n), .mac_bias(mac_bias),
        .mac_En(mac_En), .mac_clear(mac_clear), .mac_last(mac_last),
        .mac_Q3(mac_Q3), .mac_Q3_valid(mac_Q3_valid),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_data(res_data)
    );

    // Memory models with one-cycle registered read.
    logic signed [7:0]  act_mem [4096];
    logic signed [7:0]  wgt_mem [4096];
    logic signed [31:0] bias_mem [1024];

    always @(posedge CLK) begin
        if (act_rd_en) act_data <= act_mem[act_addr];
        if (wgt_rd_en) wgt_data <= wgt_mem[wgt_addr];
        bias_data <= bias_mem[bias_addr];
    end

    function automatic longint beat_term(logic signed [7:0] qa, logic signed [7:0] qw,
                                         logic signed [7:0] za, logic signed [7:0] zw);
        return (longint'(qa) - longint'(za)) * (longint'(qw) - longint'(zw));
    endfunction

    // Requantize: round(acc+bias)*M0/2^31, rounding right shift by n, add Zo, saturate.
    function automatic byte requant(longint acc, longint bias, longint m0, int sh, int zo);
        longint p, y;
        p = (acc + bias) * m0;
        y = (p + (longint'(1) <<< 30)) >>> 31;
        if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        y = y + longint'(zo);
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return byte'(y);
    endfunction

    // Behavioural MAC: accumulate beats, emit the result MAC_LATENCY cycles after the last beat.
    longint            mac_acc = 0;
    logic [MAC_LATENCY-1:0] pv = '0;
    byte               pq [MAC_LATENCY];
    initial for (int s = 0; s < MAC_LATENCY; s++) pq[s] = 0;

    always @(posedge CLK) begin
        if (mac_En)
            mac_acc <= (mac_clear ? 64'sd0 : mac_acc) + beat_term(mac_Qa, mac_Qw, mac_Za, mac_Zw);
        pv    <= {pv[MAC_LATENCY-2:0], mac_En & mac_last};
        pq[0] <= requant((mac_clear ? 64'sd0 : mac_acc) + beat_term(mac_Qa, mac_Qw, mac_Za, mac_Zw),
                         longint'(mac_bias), longint'(mac_M0), int'(mac_n), int'(mac_Zo));
        for (int s = 1; s < MAC_LATENCY; s++) pq[s] <= pq[s-1];
    end
    assign mac_Q3       = pq[MAC_LATENCY-1];
    assign mac_Q3_valid = pv[MAC_LATENCY-1];

    // Cycle bookkeeping: cycle index 0 is the cycle start is held high.
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int  wr_addr_q[$], wr_cyc_q[$], done_q[$], busy_q[$];
    byte wr_data_q[$];
    int  rd_act_q[$], rd_wgt_q[$], rd_bias_q[$], rd_cyc_q[$];
    bit  bt_clr_q[$], bt_last_q[$];
    byte bt_qa_q[$], bt_qw_q[$];
    int  bt_bias_q[$], bt_cyc_q[$];

    always @(negedge CLK) begin
        if (res_wr_en) begin
            wr_addr_q.push_back(int'(res_addr));
            wr_data_q.push_back(byte'(res_data));
            wr_cyc_q.push_back(cyc - start_cyc);
        end
        if (done) done_q.push_back(cyc - start_cyc);
        if (busy) busy_q.push_back(cyc - start_cyc);
        if (act_rd_en) begin
            rd_act_q.push_back(int'(act_addr));
            rd_wgt_q.push_back(wgt_rd_en ? int'(wgt_addr) : -1);
            rd_bias_q.push_back(int'(bias_addr));
            rd_cyc_q.push_back(cyc - start_cyc);
        end
        if (mac_En) begin
            bt_clr_q.push_back(mac_clear);
            bt_last_q.push_back(mac_last);
            bt_qa_q.push_back(mac_Qa);
            bt_qw_q.push_back(mac_Qw);
            bt_bias_q.push_back(int'(mac_bias));
            bt_cyc_q.push_back(cyc - start_cyc);
        end
    end

    logic out_or;
    assign out_or = busy | done | act_rd_en | (|act_addr) | wgt_rd_en | (|wgt_addr) | (|bias_addr)
                  | (|mac_Qa) | (|mac_Qw) | (|mac_Za) | (|mac_Zw) | (|mac_Zo) | (|mac_M0) | (|mac_n)
                  | (|mac_bias) | mac_En | mac_clear | mac_last | res_wr_en | (|res_addr) | (|res_data);

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete(); done_q.delete(); busy_q.delete();
        rd_act_q.delete(); rd_wgt_q.delete(); rd_bias_q.delete(); rd_cyc_q.delete();
        bt_clr_q.delete(); bt_last_q.delete(); bt_qa_q.delete(); bt_qw_q.delete();
        bt_bias_q.delete(); bt_cyc_q.delete();
    endtask

    task automatic fill_rand(input int ab, input int wb, input int k, input int n);
        for (int i = 0; i < k; i++) act_mem[(ab + i) & 4095] = 8'($urandom);
        for (int r = 0; r < k * n; r++) wgt_mem[(wb + r) & 4095] = 8'($urandom);
        for (int j = 0; j < n; j++) bias_mem[j] = 32'($urandom_range(0, 2000)) - 32'd1000;
    endtask

    task automatic run_cmd(input string name, input int k, input int n, input int ab, input int wb,
                           input int rb, input logic signed [7:0] za, input logic signed [7:0] zw,
                           input logic signed [7:0] zo, input longint m0, input int sh,
                           input bit disturb);
        int nk, guard, bad_rd, bad_bt, n_wr, ii, jj;
        longint acc;
        byte expv;
        nk = k * n;
        @(negedge CLK);
        clear_logs();
        k_len = 10'(k); n_out = 10'(n);
        act_base = 12'(ab); wgt_base = 12'(wb); res_base = 12'(rb);
        cfg_Za = za; cfg_Zw = zw; cfg_Zo = zo; cfg_M0 = 32'(m0); cfg_n = 6'(sh);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        start = 1'b0;
        if (disturb) begin
            k_len = 10'($urandom_range(1, 9)); n_out = 10'($urandom_range(1, 9));
            act_base = 12'($urandom); wgt_base = 12'($urandom); res_base = 12'($urandom);
            cfg_Za = 8'($urandom); cfg_Zw = 8'($urandom); cfg_Zo = 8'($urandom);
            cfg_M0 = 32'($urandom); cfg_n = 6'($urandom);
            @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
        end
        guard = 0;
        while (done_q.size() == 0 && guard < nk + 60) begin
            @(negedge CLK);
            guard++;
        end
        repeat (3) @(negedge CLK);

        check({name, ":done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) check({name, ":done_cycle"}, done_q[0], (nk == 0) ? 1 : nk + 10);
        check({name, ":busy_cycles"}, busy_q.size(), (nk == 0) ? 0 : nk + 10);
        if (busy_q.size() > 0) check({name, ":busy_first"}, busy_q[0], 1);
        check({name, ":read_count"}, rd_act_q.size(), nk);
        check({name, ":beat_count"}, bt_clr_q.size(), nk);

        bad_rd = 0;
        for (int r = 0; r < nk && r < rd_act_q.size(); r++) begin
            ii = r % k; jj = r / k;
            if (rd_act_q[r] != ((ab + ii) & 4095) || rd_wgt_q[r] != ((wb + jj * k + ii) & 4095) ||
                rd_bias_q[r] != jj || rd_cyc_q[r] != r + 1) bad_rd++;
        end
        check({name, ":bad_reads"}, bad_rd, 0);

        bad_bt = 0;
        for (int b = 0; b < nk && b < bt_clr_q.size(); b++) begin
            ii = b % k; jj = b / k;
            if (bt_clr_q[b] != (ii == 0) || bt_last_q[b] != (ii == k - 1) ||
                bt_qa_q[b] != act_mem[(ab + ii) & 4095] || bt_qw_q[b] != wgt_mem[(wb + jj * k + ii) & 4095] ||
                bt_bias_q[b] != bias_mem[jj] || bt_cyc_q[b] != b + 2) bad_bt++;
        end
        check({name, ":bad_beats"}, bad_bt, 0);

        n_wr = (nk == 0) ? 0 : n;
        check({name, ":write_count"}, wr_addr_q.size(), n_wr);
        for (int j = 0; j < n_wr && j < wr_addr_q.size(); j++) begin
            acc = 0;
            for (int i = 0; i < k; i++)
                acc += beat_term(act_mem[(ab + i) & 4095], wgt_mem[(wb + j * k + i) & 4095], za, zw);
            expv = requant(acc, longint'(bias_mem[j]), m0, sh, int'(zo));
            check($sformatf("%s:wr%0d_addr", name, j), wr_addr_q[j], (rb + j) & 4095);
            check($sformatf("%s:wr%0d_data", name, j), wr_data_q[j], expv);
            check($sformatf("%s:wr%0d_cycle", name, j), wr_cyc_q[j], (j + 1) * k + 9);
        end
        $display("txn %s k=%0d n=%0d act=%03h wgt=%03h res=%03h writes=%0d done@%0d",
                 name, k, n, ab, wb, rb, wr_addr_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    endtask

    initial begin
        int k, n, ab, wb, rb;
        logic signed [7:0] za, zw, zo;
        for (int a = 0; a < 4096; a++) begin act_mem[a] = 0; wgt_mem[a] = 0; end
        for (int a = 0; a < 1024; a++) bias_mem[a] = 0;

        repeat (3) @(negedge CLK);
        check("reset_outputs", out_or, 0);
        RST = 1'b1;
        @(negedge CLK);

        // Small known dot products.
        for (int i = 0; i < 4; i++) begin
            act_mem[100 + i] = 8'(i + 1);
            wgt_mem[200 + i] = 8'sd1;
            wgt_mem[204 + i] = 8'sd2;
        end
        bias_mem[0] = 0; bias_mem[1] = 0;
        run_cmd("basic", 4, 2, 100, 200, 300, 0, 0, 0, longint'(1) <<< 30, 0, 1'b0);
        if (wr_data_q.size() == 2) begin
            check("basic:res0", wr_data_q[0], 5);
            check("basic:res1", wr_data_q[1], 10);
            check("basic:res0_cycle", wr_cyc_q[0], 13);
            check("basic:res1_cycle", wr_cyc_q[1], 17);
        end

        fill_rand(10, 20, 1, 3);
        run_cmd("k1", 1, 3, 10, 20, 40, 8'sd3, -8'sd2, 8'sd1, 64'd1500000000, 4, 1'b0);

        run_cmd("k0", 0, 5, 0, 0, 0, 0, 0, 0, 64'd1000, 0, 1'b0);
        run_cmd("n0", 5, 0, 0, 0, 0, 0, 0, 0, 64'd1000, 0, 1'b0);

        act_mem[50] = 8'sd127; wgt_mem[60] = 8'sd127; bias_mem[0] = 0;
        run_cmd("sat_hi", 1, 1, 50, 60, 70, 0, 0, 8'sd10, 64'd2147483647, 0, 1'b0);
        if (wr_data_q.size() == 1) check("sat_hi:value", wr_data_q[0], 127);
        wgt_mem[60] = -8'sd128;
        run_cmd("sat_lo", 1, 1, 50, 60, 70, 0, 0, 8'sd10, 64'd2147483647, 0, 1'b0);
        if (wr_data_q.size() == 1) check("sat_lo:value", wr_data_q[0], -128);

        fill_rand(500, 900, 3, 3);
        run_cmd("disturb", 3, 3, 500, 900, 1200, -8'sd5, 8'sd7, -8'sd3, 64'd1200000000, 6, 1'b1);

        // Asynchronous reset in the middle of the read phase.
        fill_rand(30, 40, 2, 4);
        @(negedge CLK);
        clear_logs();
        k_len = 10'd2; n_out = 10'd4; act_base = 12'd30; wgt_base = 12'd40; res_base = 12'd80;
        cfg_Zo = 8'sd9; cfg_M0 = 32'h4000_0000; cfg_n = 6'd2;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        check("mid_reset:busy_before", busy, 1);
        RST = 1'b0;
        #1;
        check("mid_reset:outputs", out_or, 0);
        @(negedge CLK);
        RST = 1'b1;
        clear_logs();
        repeat (40) @(negedge CLK);
        check("mid_reset:writes_after", wr_addr_q.size(), 0);
        check("mid_reset:busy_after", busy_q.size(), 0);
        check("mid_reset:done_after", done_q.size(), 0);
        $display("txn mid_reset k=2 n=4 writes_after=%0d", wr_addr_q.size());

        fill_rand(12'hFFE, 12'hFFD, 4, 2);
        run_cmd("wrap", 4, 2, 12'hFFE, 12'hFFD, 12'hFFF, 8'sd1, -8'sd1, 0, 64'd1100000000, 5, 1'b0);
        if (rd_act_q.size() >= 4) begin
            check("wrap:act0", rd_act_q[0], 12'hFFE);
            check("wrap:act1", rd_act_q[1], 12'hFFF);
            check("wrap:act2", rd_act_q[2], 12'h000);
            check("wrap:act3", rd_act_q[3], 12'h001);
        end

        for (int t = 0; t < 8; t++) begin
            k  = $urandom_range(1, 6);
            n  = $urandom_range(1, 5);
            ab = $urandom_range(0, 4095);
            wb = $urandom_range(0, 4095);
            rb = $urandom_range(0, 4095);
            za = 8'($urandom_range(0, 40) - 20);
            zw = 8'($urandom_range(0, 40) - 20);
            zo = 8'($urandom_range(0, 40) - 20);
            fill_rand(ab, wb, k, n);
            run_cmd($sformatf("rand%0d", t), k, n, ab, wb, rb, za, zw, zo,
                    longint'($urandom_range(32'h2000_0000, 32'h7FFF_FFFF)),
                    $urandom_range(2, 9), t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
